uart_rx: RTL and testbench

- UART receiver that is the downstream peer of the team's TX stage: it consumes the serial TXD line and reconstructs parallel bytes.
- Frame format matches TX exactly:
  - one start bit (0);
  - SIZE data bits, LSB first;
  - one stop bit (1);
  - idle line high.
- RXC runs at OVS times the bit rate. The block synchronises the line, detects the start edge, samples each bit at mid-bit and checks framing.
- A received word is delivered as a one-cycle RX_VALID strobe. A bad stop bit is reported on RX_ERR.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, start-edge detection, mid-bit sampling
// of SIZE data bits (LSB first) and stop-bit framing check at OVS x bit rate.
module uart_rx #(
    parameter int SIZE = 8,
    parameter int OVS  = 16
) (
    input  logic            RXC,
    input  logic            RX_RST_N,
    input  logic            RXD,
    output logic [SIZE-1:0] RXDATA,
    output logic            RX_VALID,
    output logic            RX_ERR,
    output logic            RX_BUSY
);

    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(SIZE + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        sync_reg;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [SIZE-1:0]   shift_reg, shift_next;
    logic [SIZE-1:0]   data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              err_reg, err_next;
    logic              s2;

    // sync_reg[0] is the first (metastable-prone) stage; only sync_reg[1] is used
    assign s2 = sync_reg[1];

    always_ff @(posedge RXC) begin
        if (!RX_RST_N) begin
            sync_reg    <= 2'b11;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], RXD};
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!s2) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            START: begin
                // Re-check the line half a bit in to reject glitches
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!s2) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {s2, shift_reg[SIZE-1:1]};
                    bit_cnt_next = bit_cnt_reg + BW'(1);
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            STOP: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next = '0;
                    if (s2) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_HI;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            // A held-low line (break) must return high before a new start is accepted
            WAIT_HI: begin
                if (s2) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign RXDATA   = data_reg;
    assign RX_VALID = valid_reg;
    assign RX_ERR   = err_reg;
    assign RX_BUSY  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven serially, expected words and
// strobe cycles are queued at drive time and checked when the DUT strobes.
module tb_uart_rx;

    localparam int SIZE = 8;
    localparam int OVS  = 16;

    logic             RXC      = 1'b0;
    logic             RX_RST_N = 1'b0;
    logic             RXD      = 1'b1;
    logic [SIZE-1:0]  RXDATA;
    logic             RX_VALID;
    logic             RX_ERR;
    logic             RX_BUSY;

    uart_rx #(
        .SIZE(SIZE),
        .OVS (OVS)
    ) dut (
        .RXC     (RXC),
        .RX_RST_N(RX_RST_N),
        .RXD     (RXD),
        .RXDATA  (RXDATA),
        .RX_VALID(RX_VALID),
        .RX_ERR  (RX_ERR),
        .RX_BUSY (RX_BUSY)
    );

    always #5 RXC = ~RXC;

    // Index of the most recent posedge
    int cyc = 0;
    always @(posedge RXC) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [SIZE-1:0] data;
        logic            err;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    logic [SIZE-1:0] last_good   = '0;
    logic            prev_strobe = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge RXC);
            #1;
        end
    endtask

    // Drives one frame, each bit held OVS cycles; called 1 time unit after a posedge.
    task automatic send_frame(input logic [SIZE-1:0] d, input logic stop);
        exp_t e;
        int   e0;
        e0     = cyc + 1;
        e.data = stop ? d : last_good;
        e.err  = !stop;
        e.cyc  = e0 + 2 + OVS / 2 + (SIZE + 1) * OVS;
        if (stop) last_good = d;
        sb.push_back(e);
        $display("drive data=0x%02h stop=%0b e0=%0d expect_strobe_at=%0d", d, stop, e0, e.cyc);
        RXD = 1'b0;
        wait_edges(OVS);
        for (int i = 0; i < SIZE; i++) begin
            RXD = d[i];
            wait_edges(OVS);
        end
        RXD = stop;
        wait_edges(OVS);
    endtask

    always @(negedge RXC) begin
        if (RX_RST_N && (RX_VALID || RX_ERR)) begin
            exp_t e;
            check("strobe_both", {31'd0, RX_VALID & RX_ERR}, 32'd0);
            check("strobe_repeat", {31'd0, prev_strobe}, 32'd0);
            check("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rx_valid", {31'd0, RX_VALID}, {31'd0, !e.err});
                check("rx_err", {31'd0, RX_ERR}, {31'd0, e.err});
                check("rxdata", 32'(RXDATA), 32'(e.data));
                check("strobe_cycle", cyc, e.cyc);
            end
            $display("recv cyc=%0d valid=%0b err=%0b rxdata=0x%02h", cyc, RX_VALID, RX_ERR, RXDATA);
        end
        prev_strobe = RX_VALID || RX_ERR;
    end

    initial begin
        repeat (30000) @(posedge RXC);
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required<30000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;

        // Reset held low with idle line
        RX_RST_N = 1'b0;
        RXD      = 1'b1;
        wait_edges(3);
        RX_RST_N = 1'b1;
        wait_edges(1);
        check("reset_rxdata", 32'(RXDATA), 32'd0);
        check("reset_valid", {31'd0, RX_VALID}, 32'd0);
        check("reset_err", {31'd0, RX_ERR}, 32'd0);
        check("reset_busy", {31'd0, RX_BUSY}, 32'd0);
        wait_edges(5);

        // Reset in the middle of the data bits aborts the frame silently
        RXD = 1'b0;
        wait_edges(OVS);
        RXD = 1'b1;
        wait_edges(OVS);
        RXD = 1'b0;
        wait_edges(10);
        check("midframe_busy", {31'd0, RX_BUSY}, 32'd1);
        RX_RST_N = 1'b0;
        RXD      = 1'b1;
        wait_edges(2);
        check("midreset_busy", {31'd0, RX_BUSY}, 32'd0);
        check("midreset_rxdata", 32'(RXDATA), 32'd0);
        check("midreset_valid", {31'd0, RX_VALID}, 32'd0);
        RX_RST_N = 1'b1;
        wait_edges(200);
        check("post_abort_rxdata", 32'(RXDATA), 32'd0);

        // Single frame
        send_frame(8'hA5, 1'b1);
        wait_edges(20);
        check("hold_a5", 32'(RXDATA), 32'h0A5);
        check("idle_after_a5", {31'd0, RX_BUSY}, 32'd0);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_edges(20);

        // Glitch: 4 low cycles, rejected at the mid-start check
        RXD = 1'b0;
        e0  = cyc + 1;
        wait_edges(4);
        RXD = 1'b1;
        wait_edges(e0 + 9 - cyc);
        check("glitch_busy_in_start", {31'd0, RX_BUSY}, 32'd1);
        wait_edges(1);
        check("glitch_back_idle", {31'd0, RX_BUSY}, 32'd0);
        wait_edges(10);
        send_frame(8'h3C, 1'b1);
        wait_edges(10);

        // Framing error followed by a held-low line
        send_frame(8'h55, 1'b0);
        wait_edges(40);
        check("break_busy", {31'd0, RX_BUSY}, 32'd1);
        check("break_rxdata", 32'(RXDATA), 32'h03C);
        RXD = 1'b1;
        wait_edges(2);
        check("break_busy_sync", {31'd0, RX_BUSY}, 32'd1);
        wait_edges(1);
        check("break_released", {31'd0, RX_BUSY}, 32'd0);
        wait_edges(10);

        // Loopback-style traffic: TX bit period 16 RXC cycles, uneven idle gaps
        send_frame(8'h01, 1'b1);
        wait_edges(3);
        send_frame(8'h80, 1'b1);
        wait_edges(OVS + 5);
        send_frame(8'hC3, 1'b1);

        for (int i = 0; i < 500 && sb.size() != 0; i++) wait_edges(1);
        check("sb_drained", sb.size(), 32'd0);
        check("final_rxdata", 32'(RXDATA), 32'h0C3);
        wait_edges(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
